// File: rtl/simt_reconv_stack.sv
// Multi-warp SIMT reconvergence stack: per-warp active mask and divergence/call stack,
// turning decoded .S/branch/call/ret events and EX branch outcomes into stalls and redirects.
module simt_reconv_stack #(
    parameter int NUM_WARPS   = 8,
    parameter int NUM_THREADS = 8,
    parameter int DEPTH       = 16,
    parameter int PC_W        = 10,
    localparam int WID_W      = $clog2(NUM_WARPS),
    localparam int SP_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tm_update,
    input  logic [WID_W-1:0]       tm_warp,
    input  logic [NUM_THREADS-1:0] tm_mask,
    input  logic                   id_valid,
    input  logic [WID_W-1:0]       id_warp,
    input  logic                   id_dots,
    input  logic                   id_condbr,
    input  logic                   id_call,
    input  logic                   id_ret,
    input  logic [PC_W-1:0]        id_pcplus4,
    input  logic                   ex_condbr,
    input  logic [WID_W-1:0]       ex_warp,
    input  logic [NUM_THREADS-1:0] ex_outcome,
    input  logic [PC_W-1:0]        ex_target,
    output logic [NUM_WARPS-1:0]   stall,
    output logic                   ex_redir_valid,
    output logic [WID_W-1:0]       ex_redir_warp,
    output logic [PC_W-1:0]        ex_redir_pc,
    output logic                   id_redir_valid,
    output logic [WID_W-1:0]       id_redir_warp,
    output logic [PC_W-1:0]        id_redir_pc,
    input  logic [WID_W-1:0]       q_warp,
    output logic [NUM_THREADS-1:0] q_am,
    output logic [SP_W-1:0]        q_sp,
    output logic [NUM_WARPS-1:0]   err_overflow,
    output logic [NUM_WARPS-1:0]   err_underflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        TOK_SYNC = 2'b00,
        TOK_DIV  = 2'b01,
        TOK_CALL = 2'b10
    } tok_e;

    typedef struct packed {
        tok_e                   tok;
        logic [PC_W-1:0]        pc;
        logic [NUM_THREADS-1:0] am;
    } entry_t;

    entry_t                 stk [NUM_WARPS][DEPTH];
    logic [NUM_THREADS-1:0] am  [NUM_WARPS];
    logic [SP_W-1:0]        sp  [NUM_WARPS];
    logic [NUM_WARPS-1:0]   pending;

    logic                   ex_ok;
    logic                   ex_uni;
    logic                   ex_div;
    logic                   ex_push;
    logic                   ex_ovf;
    logic [NUM_THREADS-1:0] ex_t;
    logic [NUM_THREADS-1:0] ex_n;
    logic [SP_W-1:0]        ex_sp;

    assign ex_sp   = sp[ex_warp];
    assign ex_t    = ex_outcome & am[ex_warp];
    assign ex_n    = ~ex_outcome & am[ex_warp];
    assign ex_ok   = ex_condbr && pending[ex_warp]
                     && !(tm_update && tm_warp == ex_warp);
    assign ex_uni  = ex_ok && (|ex_t) && !(|ex_n);
    assign ex_div  = ex_ok && (|ex_t) && (|ex_n);
    assign ex_push = ex_div && (ex_sp != SP_W'(DEPTH));
    assign ex_ovf  = ex_div && !ex_push;

    logic            id_ok;
    logic [SP_W-1:0] id_sp;
    logic            id_full;
    logic            id_empty;
    entry_t          top;
    logic            id_push;
    logic            id_pop;
    tok_e            id_tok;
    logic            id_ovf;
    logic            id_udf;
    logic            id_pend;
    logic            id_redir;

    // Pending warps ignore ID; this also makes EX win any same-warp collision.
    assign id_ok    = id_valid && !pending[id_warp]
                      && !(tm_update && tm_warp == id_warp);
    assign id_sp    = sp[id_warp];
    assign id_full  = (id_sp == SP_W'(DEPTH));
    assign id_empty = (id_sp == '0);
    assign top      = stk[id_warp][IDX_W'(id_sp - SP_W'(1))];

    always_comb begin
        id_push  = 1'b0;
        id_pop   = 1'b0;
        id_tok   = TOK_SYNC;
        id_ovf   = 1'b0;
        id_udf   = 1'b0;
        id_pend  = 1'b0;
        id_redir = 1'b0;
        if (id_ok) begin
            if (id_dots && id_condbr) begin
                id_ovf  = id_full;
                id_push = !id_full;
                id_pend = !id_full;
            end else if (id_dots) begin
                id_udf   = id_empty;
                id_pop   = !id_empty;
                id_redir = !id_empty && (top.tok == TOK_DIV);
            end else if (id_call) begin
                id_tok  = TOK_CALL;
                id_ovf  = id_full;
                id_push = !id_full;
            end else if (id_ret) begin
                if (id_empty || top.tok != TOK_CALL) begin
                    id_udf = 1'b1;
                end else begin
                    id_pop   = 1'b1;
                    id_redir = 1'b1;
                end
            end
        end
    end

    // EX and ID never push onto the same warp in one cycle (EX needs pending, ID needs not).
    always_ff @(posedge clk) begin
        if (ex_push) begin
            stk[ex_warp][IDX_W'(ex_sp)] <= '{tok: TOK_DIV, pc: ex_target, am: ex_t};
        end
        if (id_push) begin
            stk[id_warp][IDX_W'(id_sp)] <= '{tok: id_tok, pc: id_pcplus4, am: am[id_warp]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                am[i] <= '0;
                sp[i] <= '0;
            end
            pending        <= '0;
            err_overflow   <= '0;
            err_underflow  <= '0;
            ex_redir_valid <= 1'b0;
            ex_redir_warp  <= '0;
            ex_redir_pc    <= '0;
            id_redir_valid <= 1'b0;
            id_redir_warp  <= '0;
            id_redir_pc    <= '0;
        end else begin
            ex_redir_valid <= ex_uni;
            if (ex_uni) begin
                ex_redir_warp <= ex_warp;
                ex_redir_pc   <= ex_target;
            end
            id_redir_valid <= id_redir;
            if (id_redir) begin
                id_redir_warp <= id_warp;
                id_redir_pc   <= top.pc;
            end
            if (ex_ok) begin
                pending[ex_warp] <= 1'b0;
                if (ex_push) begin
                    sp[ex_warp] <= ex_sp + SP_W'(1);
                    am[ex_warp] <= ex_n;
                end
                if (ex_ovf) begin
                    err_overflow[ex_warp] <= 1'b1;
                end
            end
            if (id_push) begin
                sp[id_warp] <= id_sp + SP_W'(1);
            end
            if (id_pop) begin
                sp[id_warp] <= id_sp - SP_W'(1);
                am[id_warp] <= top.am;
            end
            if (id_pend) begin
                pending[id_warp] <= 1'b1;
            end
            if (id_ovf) begin
                err_overflow[id_warp] <= 1'b1;
            end
            if (id_udf) begin
                err_underflow[id_warp] <= 1'b1;
            end
            if (tm_update) begin
                am[tm_warp]      <= tm_mask;
                sp[tm_warp]      <= '0;
                pending[tm_warp] <= 1'b0;
            end
        end
    end

    assign stall = pending;
    assign q_am  = am[q_warp];
    assign q_sp  = sp[q_warp];

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Bench for simt_reconv_stack: directed scenarios plus random traffic
// checked against a queue-based model of the per-warp stacks.
`timescale 1ns/1ps
module tb_simt_reconv_stack;

    localparam int NW = 8;
    localparam int NT = 8;
    localparam int D  = 4;
    localparam int PW = 10;
    localparam int WW = 3;
    localparam int SW = 3;

    localparam int K_BR   = 0;
    localparam int K_SPOP = 1;
    localparam int K_CALL = 2;
    localparam int K_RET  = 3;

    logic          clk;
    logic          rst;
    logic          tm_update;
    logic [WW-1:0] tm_warp;
    logic [NT-1:0] tm_mask;
    logic          id_valid;
    logic [WW-1:0] id_warp;
    logic          id_dots;
    logic          id_condbr;
    logic          id_call;
    logic          id_ret;
    logic [PW-1:0] id_pcplus4;
    logic          ex_condbr;
    logic [WW-1:0] ex_warp;
    logic [NT-1:0] ex_outcome;
    logic [PW-1:0] ex_target;
    logic [NW-1:0] stall;
    logic          ex_redir_valid;
    logic [WW-1:0] ex_redir_warp;
    logic [PW-1:0] ex_redir_pc;
    logic          id_redir_valid;
    logic [WW-1:0] id_redir_warp;
    logic [PW-1:0] id_redir_pc;
    logic [WW-1:0] q_warp;
    logic [NT-1:0] q_am;
    logic [SW-1:0] q_sp;
    logic [NW-1:0] err_overflow;
    logic [NW-1:0] err_underflow;

    simt_reconv_stack #(
        .NUM_WARPS(NW), .NUM_THREADS(NT), .DEPTH(D), .PC_W(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .tm_update(tm_update), .tm_warp(tm_warp), .tm_mask(tm_mask),
        .id_valid(id_valid), .id_warp(id_warp), .id_dots(id_dots),
        .id_condbr(id_condbr), .id_call(id_call), .id_ret(id_ret),
        .id_pcplus4(id_pcplus4),
        .ex_condbr(ex_condbr), .ex_warp(ex_warp), .ex_outcome(ex_outcome),
        .ex_target(ex_target),
        .stall(stall),
        .ex_redir_valid(ex_redir_valid), .ex_redir_warp(ex_redir_warp),
        .ex_redir_pc(ex_redir_pc),
        .id_redir_valid(id_redir_valid), .id_redir_warp(id_redir_warp),
        .id_redir_pc(id_redir_pc),
        .q_warp(q_warp), .q_am(q_am), .q_sp(q_sp),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        int tok;
        int pc;
        int am;
    } ent_t;

    ent_t mstk [NW][$];
    int   mam   [NW];
    bit   mpend [NW];
    bit   movf  [NW];
    bit   mudf  [NW];
    bit   e_exv;
    bit   e_idv;
    int   e_exw, e_exp, e_idw, e_idp;
    int   act_am [NW];
    int   act_sp [NW];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        tm_update  = 1'b0; tm_warp = '0; tm_mask = '0;
        id_valid   = 1'b0; id_warp = '0; id_dots = 1'b0; id_condbr = 1'b0;
        id_call    = 1'b0; id_ret = 1'b0; id_pcplus4 = '0;
        ex_condbr  = 1'b0; ex_warp = '0; ex_outcome = '0; ex_target = '0;
    endtask

    task automatic drive_tm(input int w, input int mask);
        tm_update = 1'b1; tm_warp = WW'(w); tm_mask = NT'(mask);
    endtask

    task automatic drive_id(input int w, input int k, input int pc4);
        id_valid   = 1'b1; id_warp = WW'(w);
        id_dots    = (k == K_BR || k == K_SPOP);
        id_condbr  = (k == K_BR);
        id_call    = (k == K_CALL);
        id_ret     = (k == K_RET);
        id_pcplus4 = PW'(pc4);
    endtask

    task automatic drive_ex(input int w, input int outc, input int tgt);
        ex_condbr = 1'b1; ex_warp = WW'(w);
        ex_outcome = NT'(outc); ex_target = PW'(tgt);
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            mstk[w].delete();
            mam[w] = 0; mpend[w] = 0; movf[w] = 0; mudf[w] = 0;
        end
        e_exv = 0; e_idv = 0;
    endtask

    // Applies the block's rules to the current inputs and the model state.
    task automatic model_step();
        bit            pend0 [NW];
        int            w;
        logic [NT-1:0] t, n;
        ent_t          e;
        pend0 = mpend;
        e_exv = 0;
        e_idv = 0;
        w = int'(ex_warp);
        if (ex_condbr && pend0[w] && !(tm_update && int'(tm_warp) == w)) begin
            t = ex_outcome & NT'(mam[w]);
            n = ~ex_outcome & NT'(mam[w]);
            if (t != 0 && n == 0) begin
                e_exv = 1; e_exw = w; e_exp = int'(ex_target);
            end else if (t != 0) begin
                if (mstk[w].size() == D) movf[w] = 1;
                else begin
                    e.tok = 1; e.pc = int'(ex_target); e.am = int'(t);
                    mstk[w].push_back(e);
                    mam[w] = int'(n);
                end
            end
            mpend[w] = 0;
        end
        w = int'(id_warp);
        if (id_valid && !pend0[w] && !(tm_update && int'(tm_warp) == w)) begin
            if (id_dots && id_condbr) begin
                if (mstk[w].size() == D) movf[w] = 1;
                else begin
                    e.tok = 0; e.pc = int'(id_pcplus4); e.am = mam[w];
                    mstk[w].push_back(e);
                    mpend[w] = 1;
                end
            end else if (id_dots) begin
                if (mstk[w].size() == 0) mudf[w] = 1;
                else begin
                    e = mstk[w].pop_back();
                    mam[w] = e.am;
                    if (e.tok == 1) begin
                        e_idv = 1; e_idw = w; e_idp = e.pc;
                    end
                end
            end else if (id_call) begin
                if (mstk[w].size() == D) movf[w] = 1;
                else begin
                    e.tok = 2; e.pc = int'(id_pcplus4); e.am = mam[w];
                    mstk[w].push_back(e);
                end
            end else if (id_ret) begin
                if (mstk[w].size() == 0 || mstk[w][$].tok != 2) mudf[w] = 1;
                else begin
                    e = mstk[w].pop_back();
                    mam[w] = e.am;
                    e_idv = 1; e_idw = w; e_idp = e.pc;
                end
            end
        end
        if (tm_update) begin
            w = int'(tm_warp);
            mam[w] = int'(tm_mask);
            mstk[w].delete();
            mpend[w] = 0;
        end
    endtask

    task automatic check_all();
        logic [NW-1:0] es, eo, eu;
        for (int w = 0; w < NW; w++) begin
            es[w] = mpend[w]; eo[w] = movf[w]; eu[w] = mudf[w];
        end
        chk("stall", stall, es);
        chk("err_overflow", err_overflow, eo);
        chk("err_underflow", err_underflow, eu);
        chk("ex_redir_valid", ex_redir_valid, e_exv);
        if (e_exv) begin
            chk("ex_redir_warp", ex_redir_warp, e_exw);
            chk("ex_redir_pc", ex_redir_pc, e_exp);
        end
        chk("id_redir_valid", id_redir_valid, e_idv);
        if (e_idv) begin
            chk("id_redir_warp", id_redir_warp, e_idw);
            chk("id_redir_pc", id_redir_pc, e_idp);
        end
        for (int w = 0; w < NW; w++) begin
            q_warp = WW'(w);
            #1;
            act_am[w] = int'(q_am);
            act_sp[w] = int'(q_sp);
            chk("q_am", q_am, mam[w]);
            chk("q_sp", q_sp, mstk[w].size());
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        idle();
    endtask

    task automatic rand_cycle();
        int w, k, r, outc;
        int pl [$];
        if ($urandom_range(15) == 0)
            drive_tm($urandom_range(NW - 1), $urandom_range(3) == 0 ? 'hFF : $urandom_range(255));
        if ($urandom_range(1) == 1) begin
            for (int i = 0; i < NW; i++) if (mpend[i]) pl.push_back(i);
            if (pl.size() > 0 && $urandom_range(3) != 0)
                w = pl[$urandom_range(pl.size() - 1)];
            else
                w = $urandom_range(NW - 1);
            r = $urandom_range(3);
            outc = (r == 0) ? 0 : (r == 1) ? 'hFF : $urandom_range(255);
            if (mstk[w].size() == D) outc = 'hFF;
            drive_ex(w, outc, $urandom_range(1023));
        end
        if ($urandom_range(3) != 0) begin
            w = $urandom_range(NW - 1);
            r = $urandom_range(99);
            k = (r < 30) ? K_BR : (r < 55) ? K_SPOP : (r < 80) ? K_CALL : K_RET;
            if (k == K_BR && mstk[w].size() == D) k = K_RET;
            if (k == K_SPOP && mstk[w].size() > 0 && mstk[w][$].tok == 2) k = K_RET;
            drive_id(w, k, $urandom_range(1023));
        end
        cycle();
    endtask

    initial begin
        idle();
        rst    = 1'b0;
        q_warp = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_ex_warp", ex_redir_warp, 0);
        chk("rst_ex_pc", ex_redir_pc, 0);
        chk("rst_id_warp", id_redir_warp, 0);
        chk("rst_id_pc", id_redir_pc, 0);
        @(negedge clk);
        rst = 1'b1;

        drive_tm(0, 'h3F); cycle();
        drive_id(0, K_BR, 4); cycle();
        chk("div_stall_rise", stall[0], 1);
        drive_ex(0, 'h2D, 12); cycle();
        chk("div_stall_fall", stall[0], 0);
        chk("div_sp", act_sp[0], 2);
        chk("div_am", act_am[0], 'h12);
        chk("div_no_redir", ex_redir_valid, 0);
        drive_id(0, K_SPOP, 0); cycle();
        chk("reconv1_redir", id_redir_valid, 1);
        chk("reconv1_pc", id_redir_pc, 12);
        chk("reconv1_am", act_am[0], 'h2D);
        chk("reconv1_sp", act_sp[0], 1);
        drive_id(0, K_SPOP, 0); cycle();
        chk("reconv2_am", act_am[0], 'h3F);
        chk("reconv2_sp", act_sp[0], 0);
        chk("reconv2_no_redir", id_redir_valid, 0);

        drive_tm(0, 'hFF); cycle();
        drive_id(0, K_BR, 36); cycle();
        drive_ex(0, 'hFF, 40); cycle();
        chk("uni_redir", ex_redir_valid, 1);
        chk("uni_pc", ex_redir_pc, 40);
        chk("uni_am", act_am[0], 'hFF);
        chk("uni_sp", act_sp[0], 1);
        drive_id(0, K_SPOP, 0); cycle();
        drive_id(0, K_BR, 36); cycle();
        drive_ex(0, 'h00, 44); cycle();
        chk("none_taken_redir", ex_redir_valid, 0);
        chk("none_taken_sp", act_sp[0], 1);
        drive_id(0, K_SPOP, 0); cycle();

        drive_tm(3, 'h0F); cycle();
        drive_id(3, K_CALL, 100); cycle();
        chk("call_sp", act_sp[3], 1);
        drive_id(3, K_RET, 0); cycle();
        chk("ret_redir", id_redir_valid, 1);
        chk("ret_warp", id_redir_warp, 3);
        chk("ret_pc", id_redir_pc, 100);
        chk("ret_sp", act_sp[3], 0);
        drive_id(3, K_RET, 0); cycle();
        chk("ret_underflow", err_underflow[3], 1);
        chk("ret_underflow_sp", act_sp[3], 0);

        drive_tm(1, 'hFF); cycle();
        for (int i = 0; i < 5; i++) begin
            drive_id(1, K_CALL, 200 + 4 * i); cycle();
        end
        chk("ovf_sp", act_sp[1], 4);
        chk("ovf_flag", err_overflow[1], 1);
        chk("ovf_other_flag", err_overflow[2], 0);
        chk("ovf_other_sp", act_sp[2], 0);

        drive_tm(5, 'hF0); cycle();
        drive_id(5, K_BR, 200); cycle();
        drive_ex(5, 'h30, 300); cycle();
        drive_tm(0, 'hFF); cycle();
        drive_id(0, K_BR, 8); cycle();
        drive_ex(0, 'hFF, 64);
        drive_id(5, K_SPOP, 0);
        cycle();
        chk("conc_ex_valid", ex_redir_valid, 1);
        chk("conc_ex_warp", ex_redir_warp, 0);
        chk("conc_ex_pc", ex_redir_pc, 64);
        chk("conc_id_valid", id_redir_valid, 1);
        chk("conc_id_warp", id_redir_warp, 5);
        chk("conc_id_pc", id_redir_pc, 300);

        repeat (400) rand_cycle();

        drive_tm(0, 'h3F); cycle();
        drive_id(0, K_CALL, 20); cycle();
        drive_id(0, K_BR, 24); cycle();
        chk("pre_rst_stall", stall[0], 1);
        chk("pre_rst_sp", act_sp[0], 2);
        @(negedge clk);
        rst = 1'b0;
        q_warp = '0;
        #1;
        chk("async_rst_stall", stall, 0);
        chk("async_rst_sp", q_sp, 0);
        chk("async_rst_am", q_am, 0);
        chk("async_rst_ovf", err_overflow, 0);
        chk("async_rst_udf", err_underflow, 0);
        chk("async_rst_exv", ex_redir_valid, 0);
        chk("async_rst_idv", id_redir_valid, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_tm(2, 'hA5); cycle();
        drive_id(2, K_CALL, 12); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/simt_reconv_stack.md
# simt_reconv_stack

Multi-warp SIMT reconvergence stack: the parametrised successor to the single-warp SIMT controller. It holds one active mask (AM) and one divergence/call stack per warp, sits between ID/EX and IF/IB, and turns decoded `.S`/branch/call/ret events plus EX branch outcomes into per-warp stalls, PC redirects and active masks. It adds several things the single-warp block lacks:

- warp, thread, depth and PC-width parameters;
- uniform-branch detection;
- sticky overflow/underflow error flags.

## Interface
Parameters:
- NUM_WARPS, 8, warps tracked; WID_W = $clog2(NUM_WARPS)
- NUM_THREADS, 8, threads per warp (AM width)
- DEPTH, 16, stack entries per warp; SP_W = $clog2(DEPTH+1)
- PC_W, 10, PC width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- tm_update  in  1  task manager (re)initialises a warp
- tm_warp  in  WID_W  warp being initialised
- tm_mask  in  NUM_THREADS  initial AM
- id_valid  in  1  decoded instruction valid
- id_warp  in  WID_W  warp of decoded instruction
- id_dots  in  1  `.S` suffix
- id_condbr  in  1  conditional branch
- id_call  in  1  call
- id_ret  in  1  return
- id_pcplus4  in  PC_W  PC+4 of the decoded instruction
- ex_condbr  in  1  branch outcome valid
- ex_warp  in  WID_W  warp of resolved branch
- ex_outcome  in  NUM_THREADS  per-thread taken bits
- ex_target  in  PC_W  branch target
- stall  out  NUM_WARPS  per-warp fetch stall (branch pending)
- ex_redir_valid, ex_redir_warp, ex_redir_pc  out  1/WID_W/PC_W  redirect caused by EX
- id_redir_valid, id_redir_warp, id_redir_pc  out  1/WID_W/PC_W  redirect caused by pop; also the IB drop strobe
- q_warp  in  WID_W  query select
- q_am  out  NUM_THREADS  AM of q_warp (combinational read of the AM register)
- q_sp  out  SP_W  stack pointer of q_warp
- err_overflow, err_underflow  out  NUM_WARPS  sticky per-warp error flags

## Operation
Stack entry format: {token[1:0], pc[PC_W-1:0], am[NUM_THREADS-1:0]}. Token encodings: SYNC=00, DIV=01, CALL=10; 11 is never written.

Priority each cycle: tm_update, then EX, then ID. Operations on different warps in the same cycle all take effect.

- **TM update:** AM[w]=tm_mask, sp[w]=0, pending[w]=0. Error flags are not cleared. Any EX or ID operation on the same warp in that cycle is ignored.
- **ID branch.S** (dots & condbr): push {SYNC, id_pcplus4, AM}; pending[w]=1.
- **EX resolve** (ex_condbr, warp must be pending): let T = ex_outcome & AM and N = ~ex_outcome & AM.
  - T==0: no change.
  - N==0: ex_redir to ex_target; AM unchanged.
  - Otherwise: push {DIV, ex_target, T}; AM=N; no redirect.
  - In every case pending[w]=0.
- **ID non-branch .S** (dots & !condbr): pop.
  - DIV entry: AM=entry.am; id_redir to entry.pc.
  - SYNC entry: AM=entry.am; no redirect.
- **ID call:** push {CALL, id_pcplus4, AM}. The jump target itself is handled by IF.
- **ID ret:** pop.
  - CALL entry: AM=entry.am; id_redir to entry.pc.
  - Any other token: underflow flag set; the stack is left unchanged.
- **Push at sp==DEPTH:** ignored; err_overflow[w]=1.
- **Pop at sp==0:** ignored; err_underflow[w]=1.
- **ID on a pending warp:** ignored. ex_condbr on a non-pending warp is ignored.
- **Same-cycle EX and ID on one warp:** impossible by protocol, because stall blocks ID. If it does occur, EX wins and ID is dropped.

## Timing
- All state and outputs are registered on the clk rising edge. q_am and q_sp are combinational reads of registered state.
- stall[w] rises the cycle after the ID branch.S and falls the cycle after ex_condbr.
- Redirect outputs are single-cycle pulses, valid the cycle after the causing input.
- A push or pop is visible on q_sp one cycle after the causing input.
- Reset (rst=0, asynchronous, any time including mid-divergence) forces:
  - all AM, sp, pending and error flags to 0;
  - all redirect valids, stall, err_* to 0;
  - all redirect warp/pc fields to 0.
- Stack contents need no reset; they are unreadable while sp=0.

## Test plan
- **Divergence/reconvergence:** TM warp0 mask 0x3F; branch.S warp0 pc+4=4 → stall[0]=1 next cycle. EX outcome 0x2D, target 12 → stall[0]=0, q_sp=2, q_am=0x12, no redirect. .S → id_redir pc=12, q_am=0x2D, q_sp=1. .S → q_am=0x3F, q_sp=0, no redirect.
- **Uniform branch:** AM 0xFF; EX outcome 0xFF, target 40 → ex_redir pc=40, AM 0xFF, q_sp=1. Outcome 0x00 instead → no redirect.
- **Call/ret:** warp3 AM 0x0F; call pc+4=100 → q_sp=1. ret → id_redir warp3 pc=100, q_sp=0. A second ret → err_underflow[3]=1, q_sp stays 0.
- **Overflow:** DEPTH=4; five calls on warp1 → q_sp=4, err_overflow[1]=1. Warp2 is unaffected.
- **Concurrency:** EX resolve on warp0 in the same cycle as .S on warp5 → both redirects pulse in the same cycle with correct warp ids.
- **Reset mid-operation:** rst low while warp0 is pending with q_sp=2 → stall=0, q_sp=0, q_am=0 immediately, without waiting for a clock edge.
